mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 28 ++
 rtl/mul_div_unit_div_core.sv | 94 +++++++++
 rtl/mul_div_unit.sv | 118 +++++++++++
 tb/tb_mul_div_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op-bit indices, widths and FSM states.
// EXE imports this package to build mdop one-hot vectors.
package mul_div_unit_pkg;

  localparam int SINGLE_WORD = 32;
  localparam int MDOP_W      = 6;

  localparam int MDU_MULT  = 0;
  localparam int MDU_MULTU = 1;
  localparam int MDU_DIV   = 2;
  localparam int MDU_DIVU  = 3;
  localparam int MDU_MTHI  = 4;
  localparam int MDU_MTLO  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV_ITER,
    ST_DONE
  } mdu_state_e;

  // Zero or multiple set bits decode as a no-op.
  function automatic logic is_one_hot(input logic [MDOP_W-1:0] op);
    return (op != '0) && ((op & (op - MDOP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Iterative restoring divider: operand magnitudes on start, one quotient bit per cycle,
// sign-corrected {remainder, quotient} presented alongside done on the final iteration.
module div_core
  import mul_div_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     signed_i,
  input  logic [SINGLE_WORD-1:0]   dividend,
  input  logic [SINGLE_WORD-1:0]   divisor,
  output logic                     done,
  output logic [2*SINGLE_WORD-1:0] result
);

  logic                   active;
  logic [4:0]             count;
  logic [SINGLE_WORD-1:0] rem_q;
  logic [SINGLE_WORD-1:0] quo_q;
  logic [SINGLE_WORD-1:0] div_q;
  logic [SINGLE_WORD-1:0] raw_dividend_q;
  logic                   q_neg;
  logic                   r_neg;
  logic                   div_zero;

  logic [SINGLE_WORD-1:0] dividend_mag;
  logic [SINGLE_WORD-1:0] divisor_mag;
  logic [SINGLE_WORD:0]   shifted;
  logic [SINGLE_WORD:0]   diff;
  logic [SINGLE_WORD-1:0] rem_n;
  logic [SINGLE_WORD-1:0] quo_n;
  logic [SINGLE_WORD-1:0] rem_fix;
  logic [SINGLE_WORD-1:0] quo_fix;

  always_comb begin
    dividend_mag = (signed_i && dividend[SINGLE_WORD-1]) ? (~dividend + 32'd1) : dividend;
    divisor_mag  = (signed_i && divisor[SINGLE_WORD-1])  ? (~divisor + 32'd1)  : divisor;
  end

  // A non-negative trial difference means the divisor fits: keep it and shift in a 1.
  always_comb begin
    shifted = {rem_q, quo_q[SINGLE_WORD-1]};
    diff    = shifted - {1'b0, div_q};
    rem_n   = shifted[SINGLE_WORD-1:0];
    quo_n   = {quo_q[SINGLE_WORD-2:0], 1'b0};
    if (!diff[SINGLE_WORD]) begin
      rem_n = diff[SINGLE_WORD-1:0];
      quo_n = {quo_q[SINGLE_WORD-2:0], 1'b1};
    end
  end

  always_comb begin
    quo_fix = q_neg ? (~quo_n + 32'd1) : quo_n;
    rem_fix = r_neg ? (~rem_n + 32'd1) : rem_n;
    done    = active && (count == 5'd31);
    result  = div_zero ? {raw_dividend_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active         <= 1'b0;
      count          <= 5'd0;
      rem_q          <= '0;
      quo_q          <= '0;
      div_q          <= '0;
      raw_dividend_q <= '0;
      q_neg          <= 1'b0;
      r_neg          <= 1'b0;
      div_zero       <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
      count  <= 5'd0;
    end else if (start) begin
      active         <= 1'b1;
      count          <= 5'd0;
      rem_q          <= '0;
      quo_q          <= dividend_mag;
      div_q          <= divisor_mag;
      raw_dividend_q <= dividend;
      q_neg          <= signed_i && (dividend[SINGLE_WORD-1] ^ divisor[SINGLE_WORD-1]);
      r_neg          <= signed_i && dividend[SINGLE_WORD-1];
      div_zero       <= (divisor == '0);
    end else if (active) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      count <= count + 5'd1;
      if (count == 5'd31) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: two-cycle multiply, 34-cycle iterative divide, MTHI/MTLO writes.
// Stalls EXE through busy_o; flush abandons any in-flight op without touching HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic [MDOP_W-1:0]      mdop,
  input  logic [SINGLE_WORD-1:0] scr0,
  input  logic [SINGLE_WORD-1:0] scr1,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [SINGLE_WORD-1:0] hi_o,
  output logic [SINGLE_WORD-1:0] lo_o
);

  mdu_state_e             state;
  logic [SINGLE_WORD-1:0] op_a;
  logic [SINGLE_WORD-1:0] op_b;
  logic                   op_signed;
  logic                   op_ok;

  logic signed [SINGLE_WORD:0]     mul_a;
  logic signed [SINGLE_WORD:0]     mul_b;
  logic signed [2*SINGLE_WORD-1:0] product;

  logic                     div_start;
  logic                     div_done;
  logic [2*SINGLE_WORD-1:0] div_result;

  assign op_ok = valid_i && is_one_hot(mdop);

  // One 33x33 signed multiplier serves both flavours via the extension bit.
  always_comb begin
    mul_a   = {op_signed & op_a[SINGLE_WORD-1], op_a};
    mul_b   = {op_signed & op_b[SINGLE_WORD-1], op_b};
    product = mul_a * mul_b;
  end

  assign div_start = (state == ST_DIV_PREP);

  div_core u_div_core (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (flush_i),
    .signed_i (op_signed),
    .dividend (op_a),
    .divisor  (op_b),
    .done     (div_done),
    .result   (div_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else if (flush_i) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_ok) begin
            if (mdop[MDU_MTHI]) begin
              hi_o   <= scr0;
              done_o <= 1'b1;
            end else if (mdop[MDU_MTLO]) begin
              lo_o   <= scr0;
              done_o <= 1'b1;
            end else begin
              op_a      <= scr0;
              op_b      <= scr1;
              op_signed <= mdop[MDU_MULT] | mdop[MDU_DIV];
              busy_o    <= 1'b1;
              state     <= (mdop[MDU_MULT] | mdop[MDU_MULTU]) ? ST_MUL : ST_DIV_PREP;
            end
          end
        end
        ST_MUL: begin
          {hi_o, lo_o} <= product;
          busy_o       <= 1'b0;
          done_o       <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DIV_PREP: begin
          state <= ST_DIV_ITER;
        end
        ST_DIV_ITER: begin
          if (div_done) begin
            {hi_o, lo_o} <= div_result;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops
// compared against a plain-arithmetic model of MIPS MULT/MULTU/DIV/DIVU.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [5:0]  mdop;
  logic [31:0] scr0;
  logic [31:0] scr1;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b010000;
  localparam logic [5:0] OP_MTLO  = 6'b100000;

  mul_div_unit dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .mdop    (mdop),
    .scr0    (scr0),
    .scr1    (scr1),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {HI, LO} straight from the instruction definitions.
  function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int      ia;
    int      ib;
    longint  la;
    longint  lb;
    longint  q;
    longint  r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] res;
    ia = a;
    ib = b;
    la = ia;
    lb = ib;
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    if (op == OP_MULT) begin
      res = la * lb;
    end else if (op == OP_MULTU) begin
      res = ua * ub;
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (op == OP_DIV) begin
      q = la / lb;
      r = la % lb;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request for exactly one accepting edge; returns 1 ns after that edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    mdop    = op;
    scr0    = a;
    scr1    = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    mdop    = 6'd0;
  endtask

  task automatic runOp(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input int exp_busy);
    int cyc;
    int busy_cycles;
    logic [63:0] exp_val;
    exp_val = model(op, a, b);
    applyStimulus(op, a, b);
    cyc = 1;
    busy_cycles = 0;
    while (!done_o && cyc < 100) begin
      if (busy_o) busy_cycles++;
      // A stray request while stalled must be ignored.
      if (cyc == 3 && busy_o) begin
        valid_i = 1'b1;
        mdop    = OP_MTHI;
        scr0    = 32'hBAD0_BAD0;
      end else begin
        valid_i = 1'b0;
        mdop    = 6'd0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_i = 1'b0;
    mdop    = 6'd0;
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    checkOutput({tag, "_hilo"}, {hi_o, lo_o}, exp_val);
    checkOutput({tag, "_busy_in_done"}, 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse_end"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    logic [63:0] saved;
    logic [5:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen_done;
    int          sel;

    rst     = 1'b1;
    valid_i = 1'b0;
    mdop    = 6'd0;
    scr0    = 32'd0;
    scr1    = 32'd0;
    flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hilo", {hi_o, lo_o}, 64'd0);
    checkOutput("reset_busy_done", {62'd0, busy_o, done_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    runOp("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 2, 1);
    checkOutput("mult_neg_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    runOp("multu", OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 2, 1);
    checkOutput("multu_const", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 33);
    checkOutput("div_m7_2_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("divu_by0", OP_DIVU, 32'd100, 32'd0, 34, 33);
    checkOutput("divu_by0_const", {hi_o, lo_o}, {32'd100, 32'hFFFF_FFFF});
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 33);
    checkOutput("div_ovf_const", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
    runOp("div_neg_by0", OP_DIV, 32'hFFFF_FF00, 32'd0, 34, 33);

    // MTHI/MTLO commit in one cycle without ever raising busy.
    applyStimulus(OP_MTHI, 32'hAAAA_5555, 32'd0);
    checkOutput("mthi_val", {32'd0, hi_o}, {32'd0, 32'hAAAA_5555});
    checkOutput("mthi_done_busy", {62'd0, done_o, busy_o}, 64'd2);
    applyStimulus(OP_MTLO, 32'h5555_AAAA, 32'd0);
    checkOutput("mtlo_val", {hi_o, lo_o}, 64'hAAAA_5555_5555_AAAA);
    @(posedge clk);
    #1;

    // Malformed mdop values are no-ops.
    saved = {hi_o, lo_o};
    applyStimulus(6'b000000, 32'h1111_1111, 32'd1);
    checkOutput("noop_zero", {60'd0, busy_o, done_o, 2'b00}, 64'd0);
    applyStimulus(6'b010001, 32'h2222_2222, 32'd1);
    checkOutput("noop_multi", {62'd0, busy_o, done_o}, 64'd0);
    checkOutput("noop_hilo", {hi_o, lo_o}, saved);

    // Flush wins over a simultaneous request.
    flush_i = 1'b1;
    applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    flush_i = 1'b0;
    checkOutput("flush_valid_hilo", {hi_o, lo_o}, saved);
    checkOutput("flush_valid_done", 64'(done_o), 64'd0);

    // Flush at cycle 10 of a divide.
    applyStimulus(OP_DIV, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("flush_pre_busy", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    checkOutput("flush_busy", 64'(busy_o), 64'd0);
    checkOutput("flush_hilo", {hi_o, lo_o}, saved);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) seen_done++;
      @(posedge clk);
      #1;
    end
    checkOutput("flush_no_done", 64'(seen_done), 64'd0);
    checkOutput("flush_hilo_late", {hi_o, lo_o}, saved);
    applyStimulus(OP_MTLO, 32'h0000_1234, 32'd0);
    checkOutput("post_flush_mtlo", {hi_o, lo_o}, {saved[63:32], 32'h0000_1234});
    checkOutput("post_flush_done_busy", {62'd0, done_o, busy_o}, 64'd2);
    @(posedge clk);
    #1;

    // Reset at cycle 5 of a divide clears everything immediately.
    applyStimulus(OP_DIV, 32'hFFFF_0000, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_hilo", {hi_o, lo_o}, 64'd0);
    checkOutput("midrst_busy_done", {62'd0, busy_o, done_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    runOp("post_rst_div", OP_DIV, 32'h8000_0001, 32'h0000_0010, 34, 33);
    runOp("post_rst_mult", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 2, 1);

    for (int n = 0; n < 20; n++) begin
      sel = $urandom_range(0, 3);
      rop = (sel == 0) ? OP_MULT : (sel == 1) ? OP_MULTU : (sel == 2) ? OP_DIV : OP_DIVU;
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      runOp("rand", rop, ra, rb, (sel < 2) ? 2 : 34, (sel < 2) ? 1 : 33);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
